pipe_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline register for the pipelined MIPS core. It carries the RF write enable, DM write enable and mem-to-RF select, plus ALU result, store data and destination register, from Execute to Memory. Unlike a plain flop bank, it adds a valid bit, hazard-unit stall (hold) and flush (bubble insert) controls, and a configurable number of retiming stages.

---
 rtl/pipe_mem_stage_if.sv | 32 +++
 rtl/pipe_mem_stage.sv | 98 +++++++++
 tb/tb_pipe_mem_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_stage_if.sv
// E-stage inputs and M-stage outputs of the EX/MEM pipeline register.
// master drives the E side and observes the M side; slave is the register itself.
interface pipe_mem_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          VALIDE;
    logic          RFWEE;
    logic          DMWEE;
    logic          MtoRFselE;
    logic [DW-1:0] ALU_out;
    logic [DW-1:0] DMinE;
    logic [AW-1:0] RtDE;

    logic          VALIDM;
    logic          RFWEM;
    logic          DMWEM;
    logic          MtoRFselM;
    logic [DW-1:0] ALU_outM;
    logic [DW-1:0] DMinM;
    logic [AW-1:0] RtDM;

    modport master (
        output VALIDE, RFWEE, DMWEE, MtoRFselE, ALU_out, DMinE, RtDE,
        input  VALIDM, RFWEM, DMWEM, MtoRFselM, ALU_outM, DMinM, RtDM
    );

    modport slave (
        input  VALIDE, RFWEE, DMWEE, MtoRFselE, ALU_out, DMinE, RtDE,
        output VALIDM, RFWEM, DMWEM, MtoRFselM, ALU_outM, DMinM, RtDM
    );
endinterface

// File: rtl/pipe_mem_stage.sv
// EX/MEM pipeline register with valid bit, hold and bubble insert; PIPE_MEM_PERF_EN adds stall/bubble counters.
// Latency: DEPTH cycles (DEPTH 1..4); M outputs come straight from the last stage flops.
// Backpressure: STALL freezes every stage (producer holds E inputs); FLUSH overrides STALL and squashes all stages.
module pipe_mem_stage #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             STALL,
    input  logic             FLUSH,
    pipe_mem_stage_if.slave  bus,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] BUBBLE_CNT
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_mem_stage: DEPTH must be in 1..4");
        end
    endgenerate

    typedef struct packed {
        logic          vld;
        logic          rfwe;
        logic          dmwe;
        logic          mtorf;
        logic [DW-1:0] alu;
        logic [DW-1:0] dmin;
        logic [AW-1:0] rt;
    } stage_t;

    stage_t stg_in;
    stage_t stg_q [DEPTH];

    // Write enables are qualified by valid so a dead slot can never write RF or DM.
    always_comb begin
        stg_in       = '0;
        stg_in.vld   = bus.VALIDE;
        stg_in.rfwe  = bus.RFWEE & bus.VALIDE;
        stg_in.dmwe  = bus.DMWEE & bus.VALIDE;
        stg_in.mtorf = bus.MtoRFselE;
        stg_in.alu   = bus.ALU_out;
        stg_in.dmin  = bus.DMinE;
        stg_in.rt    = bus.RtDE;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn || FLUSH) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_q[k] <= '0;
            end
        end else if (!STALL) begin
            stg_q[0] <= stg_in;
            for (int k = 1; k < DEPTH; k++) begin
                stg_q[k] <= stg_q[k-1];
            end
        end
    end

    assign bus.VALIDM    = stg_q[DEPTH-1].vld;
    assign bus.RFWEM     = stg_q[DEPTH-1].rfwe;
    assign bus.DMWEM     = stg_q[DEPTH-1].dmwe;
    assign bus.MtoRFselM = stg_q[DEPTH-1].mtorf;
    assign bus.ALU_outM  = stg_q[DEPTH-1].alu;
    assign bus.DMinM     = stg_q[DEPTH-1].dmin;
    assign bus.RtDM      = stg_q[DEPTH-1].rt;

`ifdef PIPE_MEM_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    // Both counters saturate so a long run never wraps back to a small value.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (FLUSH) begin
            if (bubble_cnt_q != '1) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end else if (STALL) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign BUBBLE_CNT = bubble_cnt_q;
`else
    assign STALL_CNT  = '0;
    assign BUBBLE_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: DEPTH=1 and DEPTH=3 instances share stimulus and are checked
// against a queue model of the pipeline plus a directed vector table and sequences.
module tb_pipe_mem_stage;

    localparam int CNT_W  = 4;
    localparam int CNTMAX = 15;
`ifdef PIPE_MEM_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        vld;
        logic        rfwe;
        logic        dmwe;
        logic        mtorf;
        logic [31:0] alu;
        logic [31:0] dmin;
        logic [4:0]  rt;
    } ent_t;

    typedef struct {
        logic rstn;
        logic stall;
        logic flush;
        ent_t in;
        ent_t x;
    } vec_t;

    logic CLK = 1'b0;
    logic rstn, stall, flush;
    logic [CNT_W-1:0] scnt1, bcnt1, scnt3, bcnt3;

    pipe_mem_stage_if #(.DW(32), .AW(5)) ia ();
    pipe_mem_stage_if #(.DW(32), .AW(5)) ib ();

    assign ib.VALIDE    = ia.VALIDE;
    assign ib.RFWEE     = ia.RFWEE;
    assign ib.DMWEE     = ia.DMWEE;
    assign ib.MtoRFselE = ia.MtoRFselE;
    assign ib.ALU_out   = ia.ALU_out;
    assign ib.DMinE     = ia.DMinE;
    assign ib.RtDE      = ia.RtDE;

    pipe_mem_stage #(.DW(32), .AW(5), .DEPTH(1), .CNT_W(CNT_W)) dut1 (
        .CLK(CLK), .RSTn(rstn), .STALL(stall), .FLUSH(flush),
        .bus(ia), .STALL_CNT(scnt1), .BUBBLE_CNT(bcnt1)
    );

    pipe_mem_stage #(.DW(32), .AW(5), .DEPTH(3), .CNT_W(CNT_W)) dut3 (
        .CLK(CLK), .RSTn(rstn), .STALL(stall), .FLUSH(flush),
        .bus(ib), .STALL_CNT(scnt3), .BUBBLE_CNT(bcnt3)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference: each pipeline is a queue of DEPTH entries, the M outputs are its oldest entry.
    ent_t q1[$];
    ent_t q3[$];
    int   m_scnt = 0;
    int   m_bcnt = 0;

    function automatic ent_t mk(logic v, logic rf, logic dm, logic mt,
                                logic [31:0] alu, logic [31:0] dmin, logic [4:0] rt);
        ent_t e;
        e.vld = v; e.rfwe = rf; e.dmwe = dm; e.mtorf = mt;
        e.alu = alu; e.dmin = dmin; e.rt = rt;
        return e;
    endfunction

    function automatic vec_t mkv(logic r, logic s, logic f, ent_t in, ent_t x);
        vec_t v;
        v.rstn = r; v.stall = s; v.flush = f; v.in = in; v.x = x;
        return v;
    endfunction

    function automatic ent_t out1();
        return mk(ia.VALIDM, ia.RFWEM, ia.DMWEM, ia.MtoRFselM, ia.ALU_outM, ia.DMinM, ia.RtDM);
    endfunction

    function automatic ent_t out3();
        return mk(ib.VALIDM, ib.RFWEM, ib.DMWEM, ib.MtoRFselM, ib.ALU_outM, ib.DMinM, ib.RtDM);
    endfunction

    task automatic drive(logic r, logic s, logic f, ent_t e);
        rstn = r; stall = s; flush = f;
        ia.VALIDE = e.vld; ia.RFWEE = e.rfwe; ia.DMWEE = e.dmwe; ia.MtoRFselE = e.mtorf;
        ia.ALU_out = e.alu; ia.DMinE = e.dmin; ia.RtDE = e.rt;
    endtask

    task automatic clear_model();
        q1.delete();
        q3.delete();
        q1.push_back('0);
        for (int i = 0; i < 3; i++) q3.push_back('0);
    endtask

    task automatic model_step();
        ent_t e;
        e = mk(ia.VALIDE, ia.RFWEE & ia.VALIDE, ia.DMWEE & ia.VALIDE, ia.MtoRFselE,
               ia.ALU_out, ia.DMinE, ia.RtDE);
        if (!rstn) begin
            clear_model();
            m_scnt = 0;
            m_bcnt = 0;
        end else if (flush) begin
            clear_model();
            if (m_bcnt < CNTMAX) m_bcnt++;
        end else if (stall) begin
            if (m_scnt < CNTMAX) m_scnt++;
        end else begin
            q1.push_front(e); void'(q1.pop_back());
            q3.push_front(e); void'(q3.pop_back());
        end
    endtask

    // Inputs only change 1 time unit after an edge, so the model sees the same values as the DUT.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic chk_ent(string name, ent_t act, ent_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (vld rfwe dmwe mtorf alu dmin rt)", name, act, exp);
        end
    endtask

    task automatic chk_cnt(string name, logic [CNT_W-1:0] act, logic [CNT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_alu(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk_ent({tag, "_d1"}, out1(), q1[$]);
        chk_ent({tag, "_d3"}, out3(), q3[$]);
        chk_cnt({tag, "_scnt1"}, scnt1, PERF ? 4'(m_scnt) : 4'd0);
        chk_cnt({tag, "_bcnt1"}, bcnt1, PERF ? 4'(m_bcnt) : 4'd0);
        chk_cnt({tag, "_scnt3"}, scnt3, PERF ? 4'(m_scnt) : 4'd0);
        chk_cnt({tag, "_bcnt3"}, bcnt3, PERF ? 4'(m_bcnt) : 4'd0);
    endtask

    vec_t tbl[13];
    ent_t z;
    ent_t ones;

    initial begin
        z    = '0;
        ones = mk(1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F);
        clear_model();

        // Expected column is the DEPTH=1 M-stage after the edge.
        tbl[0]  = mkv(0, 1, 1, ones, z);
        tbl[1]  = mkv(0, 1, 1, ones, z);
        tbl[2]  = mkv(1, 0, 0, mk(1, 1, 0, 0, 32'h0000_1234, 32'h0, 5), mk(1, 1, 0, 0, 32'h0000_1234, 32'h0, 5));
        tbl[3]  = mkv(1, 0, 0, mk(1, 0, 0, 0, 32'hAAAA_0001, 32'h11, 7), mk(1, 0, 0, 0, 32'hAAAA_0001, 32'h11, 7));
        for (int i = 4; i < 8; i++)
            tbl[i] = mkv(1, 1, 0, mk(1, 0, 0, 0, 32'hBBBB_0002, 32'h22, 8), mk(1, 0, 0, 0, 32'hAAAA_0001, 32'h11, 7));
        tbl[8]  = mkv(1, 0, 0, mk(1, 0, 0, 0, 32'hBBBB_0002, 32'h22, 8), mk(1, 0, 0, 0, 32'hBBBB_0002, 32'h22, 8));
        tbl[9]  = mkv(1, 1, 1, mk(1, 0, 1, 0, 32'h5, 32'h0, 3), z);
        tbl[10] = mkv(1, 0, 0, mk(1, 0, 1, 1, 32'h6, 32'h33, 4), mk(1, 0, 1, 1, 32'h6, 32'h33, 4));
        tbl[11] = mkv(1, 0, 0, mk(0, 1, 1, 1, 32'h9, 32'h9, 9), mk(0, 0, 0, 1, 32'h9, 32'h9, 9));
        tbl[12] = mkv(0, 0, 0, mk(1, 1, 1, 1, 32'h7, 32'h7, 7), z);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rstn, tbl[i].stall, tbl[i].flush, tbl[i].in);
            tick();
            chk_ent($sformatf("vec%0d", i), out1(), tbl[i].x);
            check_model($sformatf("vec%0d", i));
        end

        // DEPTH=3 latency: a value injected on edge n appears on edge n+2, then back-to-back.
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) drive(1, 0, 0, mk(1, 0, 0, 0, 32'(i), 32'h0, 5'd1));
            else        drive(1, 0, 0, z);
            tick();
            chk_alu($sformatf("lat_e%0d", i), ib.ALU_outM, (i >= 3) ? 32'(i - 2) : 32'h0);
            check_model($sformatf("lat%0d", i));
        end

        // Counters: saturation under a long stall, bubble count, then reset.
        drive(0, 0, 0, z);
        tick();
        drive(1, 1, 0, mk(1, 1, 0, 0, 32'hC0DE, 32'h1, 2));
        for (int i = 0; i < 20; i++) tick();
        chk_cnt("stall_sat1", scnt1, PERF ? 4'd15 : 4'd0);
        chk_cnt("stall_sat3", scnt3, PERF ? 4'd15 : 4'd0);
        check_model("stall_sat");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, z);
            tick();
            drive(1, 0, 0, z);
            tick();
        end
        chk_cnt("bubble3_d1", bcnt1, PERF ? 4'd3 : 4'd0);
        chk_cnt("bubble3_d3", bcnt3, PERF ? 4'd3 : 4'd0);
        chk_cnt("stall_keep", scnt1, PERF ? 4'd15 : 4'd0);
        drive(0, 0, 0, z);
        tick();
        chk_cnt("rst_scnt", scnt1, 4'd0);
        chk_cnt("rst_bcnt", bcnt1, 4'd0);
        check_model("cnt_rst");

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom, $urandom, 5'($urandom)));
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
